shift_operand_stage: RTL

// - Pipeline stage directly upstream of the barrel shifter in the RiscBEE execute path.
// - Accepts decoded RV32I shift instructions (SLL/SRL/SRA and SLLI/SRLI/SRAI) with operands.
// - Selects the shift amount, decodes direction and arithmetic mode, and registers the
//   A / shamt / right / arith bundle plus the rd tag.
// - Valid/ready on both sides; a 2-entry skid buffer gives full throughput under back-pressure.

---
 rtl/shift_operand_stage.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/shift_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : shift_operand_stage
// Description : Decodes RV32I shift instructions into an A/shamt/right/arith
//               bundle in front of the barrel shifter. A 2-entry output/skid
//               buffer keeps full throughput under back-pressure.
//               Optional build macro: ILLEGAL_CHECK_EN (full funct7 check).
// Revision    : 1.0 - initial release
// ============================================================================
module shift_operand_stage #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_is_imm,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [WIDTH-1:0] in_rs1,
    input  logic [WIDTH-1:0] in_rs2,
    input  logic [SHW-1:0]   in_imm_sh,
    input  logic [4:0]       in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [SHW-1:0]   out_shamt,
    output logic             out_right,
    output logic             out_arith,
    output logic [4:0]       out_rd,
    output logic             out_illegal
);

    localparam int c_BUNDLE_W = WIDTH + SHW + 1 + 1 + 5 + 1;

    // State bits are {skid_full, out_valid}
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_BUNDLE_W-1:0] r_out;
    logic [c_BUNDLE_W-1:0] r_skid;
    logic [c_BUNDLE_W-1:0] w_bundle;
    logic                  w_is_sll;
    logic                  w_is_srx;
    logic [SHW-1:0]        w_shamt;
    logic                  w_illegal;
    logic                  w_acc;
    logic                  w_drain;
    logic                  w_load_out_in;
    logic                  w_load_out_skid;
    logic                  w_load_skid;
    logic                  w_unused_ok;

    assign w_is_sll = (in_funct3 == 3'b001);
    assign w_is_srx = (in_funct3 == 3'b101);
    assign w_shamt  = in_is_imm ? in_imm_sh : in_rs2[SHW-1:0];

`ifdef ILLEGAL_CHECK_EN
    assign w_illegal = !(w_is_sll || w_is_srx)
                     || ((in_funct7 != 7'b0000000) && (in_funct7 != 7'b0100000))
                     || (w_is_sll && (in_funct7 == 7'b0100000));
`else
    assign w_illegal = !(w_is_sll || w_is_srx);
`endif

    // Upper rs2 bits never affect the shift amount
    assign w_unused_ok = &{1'b0, in_rs2[WIDTH-1:SHW], in_funct7};

    assign w_bundle = {in_rs1, w_shamt, w_is_srx, w_is_srx & in_funct7[5], in_rd, w_illegal};

    assign in_ready  = ~r_state[1];
    assign out_valid = r_state[0];
    assign w_acc     = in_valid & in_ready;
    assign w_drain   = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_load_out_in   = 1'b0;
        w_load_out_skid = 1'b0;
        w_load_skid     = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_acc) begin
                    w_state_nxt   = ST_ONE;
                    w_load_out_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_drain && w_acc) begin
                    w_load_out_in = 1'b1;
                end else if (w_drain) begin
                    w_state_nxt = ST_EMPTY;
                end else if (w_acc) begin
                    w_state_nxt = ST_FULL;
                    w_load_skid = 1'b1;
                end
            end
            ST_FULL: begin
                if (w_drain) begin
                    w_state_nxt     = ST_ONE;
                    w_load_out_skid = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out  <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_out_in) begin
                r_out <= w_bundle;
            end else if (w_load_out_skid) begin
                r_out <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_bundle;
            end
        end
    end

    assign {out_a, out_shamt, out_right, out_arith, out_rd, out_illegal} = r_out;

endmodule
`default_nettype wire
